noise_summator: RTL and testbench
=================================

# noise_summator

Gaussian-noise back end for the noise signal path (SIGNAL_TYPE 3). It consumes the twelve 12-bit uniform samples RND1..RND12 and the SUM_START/SUM_STOP framing produced by `noise_generator`. Each sample set is summed, with the central-limit theorem giving an approximately Gaussian result. The block then scales the sum to the required mean and sigma and delivers one 12-bit unsigned sample per clock to the output register.

## Interface
- DATA_WIDTH, 12: width of each RND input and of NOISE_OUT.
- SUM_OFFSET, 24570: mean of the 12-sample sum, 12·4095/2 rounded down.
- SCALE_NUM, 683: sigma scale numerator; 683/4096 ≈ 1/6, which maps sigma 4096 to about 682.
- SCALE_SHIFT, 12: arithmetic right shift applied after the multiply.
- M_REQ, 2047: required output mean.
- CLK  in  1  clock; all logic on posedge.
- RESET  in  1  reset RESET, synchronous, active-high; clock CLK.
- SUM_START  in  1  frame-start pulse from the generator.
- SUM_STOP  in  1  marks the last sample set of the frame.
- RND1..RND12  in  12 each  uniform samples; may be Z/X outside a frame.
- NOISE_OUT  out  12  Gaussian sample, unsigned, saturated to 0..4095.
- NOISE_VALID  out  1  NOISE_OUT holds a valid sample this cycle.
- NOISE_LAST  out  1  qualifies the final sample of a frame; only high together with NOISE_VALID.
- BUSY  out  1  a frame is being captured or samples are still in the pipeline.

## Operation
- **Frame capture (`in_frame` flag)**
  - Idle, SUM_START sampled high: set in_frame. RND is not captured on that edge.
  - in_frame high: every edge captures RND1..12 as one sample set.
  - in_frame high and SUM_STOP sampled high: that edge captures the last set, tags it last, and clears in_frame.
  - A frame of N sets therefore occupies N consecutive capture edges. N = 1 is legal.
- **Pipeline**: six register stages, each carrying a valid bit and a last bit.
  - S1: six pairwise sums, 13 b.
  - S2: three sums, 14 b.
  - S3: total, 16 b unsigned; maximum 49140.
  - S4: d = S3 − SUM_OFFSET, 17 b signed.
  - S5: p = (d·SCALE_NUM) >>> SCALE_SHIFT, using a 28 b signed product and an arithmetic shift (floor).
  - Output: NOISE_OUT = sat(p + M_REQ), clamped to the range 0..4095.
- **BUSY** = in_frame OR any valid bit in S1..S5. It is low in the cycle where NOISE_LAST is shown, unless a new frame has already started.
- **Boundary rules**
  - SUM_START while in_frame: ignored; the current frame continues.
  - SUM_START and SUM_STOP both high while idle: start is taken, stop is ignored.
  - SUM_STOP while idle: ignored.
  - Back-to-back frames: a SUM_START on the edge right after the last capture starts a new frame. The pipeline is not drained first, so the frames overlap in flight.
  - Z/X on RND while not in_frame: never captured, and never propagates into a valid bit.
  - RESET mid-frame: clears in_frame and all valid/last bits. In-flight samples are discarded and never appear on the output.
- **Outputs when not valid**: NOISE_OUT = 0, NOISE_LAST = 0. The output is never driven Z.

## Timing
- **Reset values** after the reset edge: NOISE_OUT = 0, NOISE_VALID = 0, NOISE_LAST = 0, BUSY = 0, in_frame = 0, all stage valid bits 0.
- **Latency**: a set captured at edge c appears on NOISE_OUT with NOISE_VALID = 1 after edge c+5.
- **Throughput**: one sample per clock, with no stalls and no backpressure.
- **First capture**: if SUM_START is sampled at edge s, the first capture is at edge s+1 and the first output is after edge s+6.
- **BUSY timing**: rises after edge s.

## Test plan
1. **Reset values**: assert RESET for 2 cycles with random inputs → all outputs 0; BUSY 0; no NOISE_VALID for 20 cycles while SUM_START stays 0 and RND is Z.
2. **Single frame, N = 1**: pulse SUM_START at edge s; at edge s+1 hold RND all 2047 with SUM_STOP = 1 → exactly one output of 2045 after edge s+6, NOISE_LAST = 1; BUSY low the following cycle.
3. **Arithmetic and saturation, N = 5**: capture vectors in order
   - all 0 → expect 0 (saturated from −2050);
   - all 4095 → expect 4095 (saturated from 6143);
   - all 2047 → expect 2045;
   - all 2048 → expect 2048;
   - six 0 and six 4095 → expect 2047.
   Outputs appear on 5 consecutive cycles; NOISE_LAST only on the fifth.
4. **Back-to-back frames**: frame A of N = 3, then SUM_START on the edge after A's SUM_STOP, then frame B of N = 2 → 5 valid outputs in order; NOISE_LAST on A's 3rd and B's 2nd; BUSY stays high throughout.
5. **Reset mid-frame**: assert RESET after 2 captures of a 10-set frame → no NOISE_VALID afterward; BUSY = 0 after the reset edge. A new frame started after reset then produces correct results.
6. **Protocol errors**: SUM_START pulsed again mid-frame, and SUM_STOP pulsed while idle → frame length is unchanged and no spurious outputs occur; Z on RND outside the frame never yields X on NOISE_OUT or NOISE_VALID.

Source files
------------

// File: rtl/noise_summator.sv
// noise_summator
//   Gaussian-noise back end. Sums each captured set of twelve uniform samples
//   (central-limit approximation to a Gaussian), removes the mean of the sum,
//   scales to the required sigma, re-centres on M_REQ and saturates to an
//   unsigned DATA_WIDTH sample. One sample per clock, fixed 5-cycle latency
//   from capture edge to NOISE_OUT.
//
// Ports
//   CLK          clock, all logic on posedge
//   RESET        synchronous, active-high reset
//   SUM_START    frame-start pulse (taken only when idle)
//   SUM_STOP     marks the last sample set of the frame
//   RND1..RND12  uniform samples, captured only while a frame is open
//   NOISE_OUT    Gaussian sample, 0 whenever NOISE_VALID is low
//   NOISE_VALID  NOISE_OUT holds a valid sample
//   NOISE_LAST   final sample of a frame, only with NOISE_VALID
//   BUSY         frame open or samples still in flight
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no frame open; SUM_START opens one, SUM_STOP is ignored
// ST_CAPT | in_frame: RND captured every edge, SUM_STOP closes the frame

module noise_summator #(
    parameter int DATA_WIDTH  = 12,
    parameter int SUM_OFFSET  = 24570,
    parameter int SCALE_NUM   = 683,
    parameter int SCALE_SHIFT = 12,
    parameter int M_REQ       = 2047
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SUM_START,
    input  logic                  SUM_STOP,
    input  logic [DATA_WIDTH-1:0] RND1,
    input  logic [DATA_WIDTH-1:0] RND2,
    input  logic [DATA_WIDTH-1:0] RND3,
    input  logic [DATA_WIDTH-1:0] RND4,
    input  logic [DATA_WIDTH-1:0] RND5,
    input  logic [DATA_WIDTH-1:0] RND6,
    input  logic [DATA_WIDTH-1:0] RND7,
    input  logic [DATA_WIDTH-1:0] RND8,
    input  logic [DATA_WIDTH-1:0] RND9,
    input  logic [DATA_WIDTH-1:0] RND10,
    input  logic [DATA_WIDTH-1:0] RND11,
    input  logic [DATA_WIDTH-1:0] RND12,
    output logic [DATA_WIDTH-1:0] NOISE_OUT,
    output logic                  NOISE_VALID,
    output logic                  NOISE_LAST,
    output logic                  BUSY
);

    localparam int P1_W   = DATA_WIDTH + 1;       // pairwise sum
    localparam int P2_W   = DATA_WIDTH + 2;       // sum of four
    localparam int SUM_W  = DATA_WIDTH + 4;       // sum of twelve
    localparam int D_W    = SUM_W + 1;            // signed deviation
    localparam int PROD_W = D_W + 11;             // signed product with SCALE_NUM
    localparam int P_W    = PROD_W - SCALE_SHIFT; // scaled deviation

    typedef enum logic {ST_IDLE, ST_CAPT} state_t;

    state_t state_q, state_d;
    logic   cap_vld, cap_last;

    logic [DATA_WIDTH-1:0] rnd [12];

    logic [P1_W-1:0]         s1_sum_q [6];
    logic [P1_W-1:0]         s1_sum_d [6];
    logic [P2_W-1:0]         s2_sum_q [3];
    logic [P2_W-1:0]         s2_sum_d [3];
    logic [SUM_W-1:0]        s3_sum_q, s3_sum_d;
    logic signed [D_W-1:0]   s4_dif_q, s4_dif_d;
    logic signed [P_W-1:0]   s5_p_q, s5_p_d;
    logic [DATA_WIDTH-1:0]   noise_out_q, noise_out_d;

    logic [5:1] vld_q, vld_d;
    logic [5:1] last_q, last_d;
    logic       noise_valid_q, noise_valid_d;
    logic       noise_last_q, noise_last_d;

    logic signed [PROD_W-1:0] prod;
    logic [P_W:0]             re_mean;
    logic                     unused_prod_lsbs;

    always_comb begin
        rnd[0]  = RND1;  rnd[1]  = RND2;  rnd[2]  = RND3;  rnd[3]  = RND4;
        rnd[4]  = RND5;  rnd[5]  = RND6;  rnd[6]  = RND7;  rnd[7]  = RND8;
        rnd[8]  = RND9;  rnd[9]  = RND10; rnd[10] = RND11; rnd[11] = RND12;
    end

    // Frame-capture FSM
    always_comb begin
        state_d  = state_q;
        cap_vld  = 1'b0;
        cap_last = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (SUM_START) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                cap_vld = 1'b1;
                if (SUM_STOP) begin
                    cap_last = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Data stages only load when their input is valid, so undriven RND
    // outside a frame never enters the datapath registers.
    always_comb begin
        s1_sum_d = s1_sum_q;
        s2_sum_d = s2_sum_q;
        s3_sum_d = s3_sum_q;
        s4_dif_d = s4_dif_q;
        s5_p_d   = s5_p_q;

        if (cap_vld) begin
            for (int i = 0; i < 6; i++) begin
                s1_sum_d[i] = P1_W'(rnd[2*i]) + P1_W'(rnd[2*i+1]);
            end
        end
        if (vld_q[1]) begin
            for (int i = 0; i < 3; i++) begin
                s2_sum_d[i] = P2_W'(s1_sum_q[2*i]) + P2_W'(s1_sum_q[2*i+1]);
            end
        end
        if (vld_q[2]) begin
            s3_sum_d = SUM_W'(s2_sum_q[0]) + SUM_W'(s2_sum_q[1]) + SUM_W'(s2_sum_q[2]);
        end
        if (vld_q[3]) begin
            s4_dif_d = $signed({1'b0, s3_sum_q}) - $signed(D_W'(SUM_OFFSET));
        end

        prod = $signed({{(PROD_W-D_W){s4_dif_q[D_W-1]}}, s4_dif_q})
             * $signed(PROD_W'(SCALE_NUM));
        // Dropping the low SCALE_SHIFT bits of a two's-complement value is an
        // arithmetic right shift, i.e. floor division by 2**SCALE_SHIFT.
        unused_prod_lsbs = ^prod[SCALE_SHIFT-1:0];
        if (vld_q[4]) begin
            s5_p_d = prod[PROD_W-1:SCALE_SHIFT];
        end

        re_mean = {s5_p_q[P_W-1], s5_p_q} + (P_W+1)'(M_REQ);
        noise_out_d = '0;
        if (vld_q[5]) begin
            if (re_mean[P_W]) begin
                noise_out_d = '0;
            end else if (|re_mean[P_W-1:DATA_WIDTH]) begin
                noise_out_d = '1;
            end else begin
                noise_out_d = re_mean[DATA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        vld_d         = {vld_q[4:1], cap_vld};
        last_d        = {vld_q[4:1] & last_q[4:1], cap_last};
        noise_valid_d = vld_q[5];
        noise_last_d  = vld_q[5] & last_q[5];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            vld_q         <= '0;
            last_q        <= '0;
            noise_valid_q <= 1'b0;
            noise_last_q  <= 1'b0;
            noise_out_q   <= '0;
            s1_sum_q      <= '{default: '0};
            s2_sum_q      <= '{default: '0};
            s3_sum_q      <= '0;
            s4_dif_q      <= '0;
            s5_p_q        <= '0;
        end else begin
            state_q       <= state_d;
            vld_q         <= vld_d;
            last_q        <= last_d;
            noise_valid_q <= noise_valid_d;
            noise_last_q  <= noise_last_d;
            noise_out_q   <= noise_out_d;
            s1_sum_q      <= s1_sum_d;
            s2_sum_q      <= s2_sum_d;
            s3_sum_q      <= s3_sum_d;
            s4_dif_q      <= s4_dif_d;
            s5_p_q        <= s5_p_d;
        end
    end

    assign NOISE_OUT   = noise_out_q;
    assign NOISE_VALID = noise_valid_q;
    assign NOISE_LAST  = noise_last_q;
    assign BUSY        = (state_q == ST_CAPT) | (|vld_q);

endmodule

// File: tb/tb_noise_summator.sv
// Testbench for noise_summator: scoreboard of expected samples pushed at
// capture time from an integer model, popped when NOISE_VALID is seen.

module tb_noise_summator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SUM_START = 1'b0;
    logic        SUM_STOP = 1'b0;
    logic [11:0] rnd_v [12];
    logic [11:0] NOISE_OUT;
    logic        NOISE_VALID, NOISE_LAST, BUSY;

    typedef struct {
        int val;
        int last;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    noise_summator dut (
        .CLK(CLK), .RESET(RESET), .SUM_START(SUM_START), .SUM_STOP(SUM_STOP),
        .RND1(rnd_v[0]), .RND2(rnd_v[1]), .RND3(rnd_v[2]), .RND4(rnd_v[3]),
        .RND5(rnd_v[4]), .RND6(rnd_v[5]), .RND7(rnd_v[6]), .RND8(rnd_v[7]),
        .RND9(rnd_v[8]), .RND10(rnd_v[9]), .RND11(rnd_v[10]), .RND12(rnd_v[11]),
        .NOISE_OUT(NOISE_OUT), .NOISE_VALID(NOISE_VALID),
        .NOISE_LAST(NOISE_LAST), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic int model();
        int     s;
        int     d;
        longint p;
        int     q;
        int     o;
        s = 0;
        for (int i = 0; i < 12; i++) s += int'(rnd_v[i]);
        d = s - 24570;
        p = longint'(d) * 683;
        if (p >= 0) q = int'(p / 4096);
        else        q = -int'((-p + 4095) / 4096);
        o = q + 2047;
        if (o < 0)    o = 0;
        if (o > 4095) o = 4095;
        return o;
    endfunction

    task automatic rnd_z();
        for (int i = 0; i < 12; i++) rnd_v[i] = 'z;
    endtask

    task automatic set_uni(input int lo, input int hi);
        for (int i = 0; i < 12; i++) rnd_v[i] = (i < 6) ? 12'(lo) : 12'(hi);
    endtask

    task automatic set_rand();
        for (int i = 0; i < 12; i++) rnd_v[i] = 12'($urandom_range(0, 4095));
    endtask

    // entered and left at negedge
    task automatic start_frame();
        SUM_START = 1'b1;
        @(posedge CLK); #2;
        chk("busy_rise", BUSY, 1);
        @(negedge CLK);
        SUM_START = 1'b0;
    endtask

    // rnd_v must already hold the set; captured on the coming edge
    task automatic cap(input bit last);
        exp_t e;
        SUM_STOP = last;
        e.val  = model();
        e.last = last;
        e.cyc  = cyc + 1 + 5;
        sb.push_back(e);
        @(posedge CLK); #2;
        chk("busy_frame", BUSY, 1);
        @(negedge CLK);
        SUM_STOP = 1'b0;
        rnd_z();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge CLK); #2;
            n++;
            if (sb.size() != 0) chk("busy_pipe", BUSY, 1);
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end else begin
            chk("busy_after_last", BUSY, 0);
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // output monitor / scoreboard compare
    always begin
        @(posedge CLK); #1;
        if (mon_en) begin
            if (NOISE_VALID === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("noise_out", int'(NOISE_OUT), e.val);
                    chk("noise_last", int'(NOISE_LAST), e.last);
                    chk("latency_cycle", cyc, e.cyc);
                end
            end else begin
                chk("idle_outputs",
                    int'({$isunknown(NOISE_VALID), $isunknown(NOISE_OUT), NOISE_LAST, NOISE_OUT}), 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rnd_z();
        // 1: reset with random inputs
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) begin
            set_rand();
            SUM_START = 1'($urandom_range(0, 1));
            SUM_STOP  = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        RESET = 1'b0;
        SUM_START = 1'b0;
        SUM_STOP = 1'b0;
        rnd_z();
        chk("rst_out", int'(NOISE_OUT), 0);
        chk("rst_valid", int'(NOISE_VALID), 0);
        chk("rst_last", int'(NOISE_LAST), 0);
        chk("rst_busy", int'(BUSY), 0);
        mon_en = 1'b1;
        idle(20);
        chk("idle_busy", int'(BUSY), 0);

        // 2: single frame N=1
        start_frame();
        set_uni(2047, 2047);
        cap(1'b1);
        drain();

        // 3: arithmetic and saturation, N=5
        start_frame();
        set_uni(0, 0);       cap(1'b0);
        set_uni(4095, 4095); cap(1'b0);
        set_uni(2047, 2047); cap(1'b0);
        set_uni(2048, 2048); cap(1'b0);
        set_uni(0, 4095);    cap(1'b1);
        drain();

        // 4: back-to-back frames A (N=3) then B (N=2)
        start_frame();
        for (int i = 0; i < 3; i++) begin
            set_rand();
            cap(i == 2);
        end
        start_frame();
        for (int i = 0; i < 2; i++) begin
            set_rand();
            cap(i == 1);
        end
        drain();

        // 5: reset mid-frame of a 10-set frame, then a clean frame
        start_frame();
        set_rand(); cap(1'b0);
        set_rand(); cap(1'b0);
        set_rand();
        RESET = 1'b1;
        sb.delete();
        @(posedge CLK); #2;
        chk("midrst_busy", int'(BUSY), 0);
        chk("midrst_valid", int'(NOISE_VALID), 0);
        @(negedge CLK);
        RESET = 1'b0;
        rnd_z();
        idle(10);
        start_frame();
        for (int i = 0; i < 3; i++) begin
            set_rand();
            cap(i == 2);
        end
        drain();

        // 6: protocol errors
        start_frame();
        set_rand(); cap(1'b0);
        SUM_START = 1'b1;
        set_rand(); cap(1'b0);
        SUM_START = 1'b0;
        set_rand(); cap(1'b0);
        set_rand(); cap(1'b1);
        drain();
        SUM_STOP = 1'b1;
        @(negedge CLK);
        SUM_STOP = 1'b0;
        idle(10);
        chk("stop_idle_busy", int'(BUSY), 0);
        SUM_STOP = 1'b1;
        start_frame();
        SUM_STOP = 1'b0;
        set_uni(2048, 2048);
        cap(1'b1);
        drain();
        idle(5);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
